// File: rtl/hdd_ser_pkg.sv
// -----------------------------------------------------------------------------
// hdd_ser_pkg
// Shared types and constants for the hard-decision byte serializer.
//   ser_state_e      : serializer FSM state encoding
//   DEF_HDDW         : default decoder word width
//   BYTES_PER_WORD   : bytes per default-width word
//   DEF_SYNC_BYTE    : default frame marker value
//   bytes_per_word() : bytes per word for an arbitrary word width
// -----------------------------------------------------------------------------
package hdd_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } ser_state_e;

    localparam int         DEF_HDDW       = 32;
    localparam int         BYTES_PER_WORD = DEF_HDDW / 8;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    function automatic int bytes_per_word(input int hddw);
        return hddw / 8;
    endfunction

endpackage

// File: rtl/hdd_word_fifo.sv
// -----------------------------------------------------------------------------
// hdd_word_fifo
// Synchronous word FIFO with registered full/empty flags.
// The caller must not write while full unless it pops in the same cycle, and
// must not pop while empty; the FIFO does not guard against either.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_wr_en     : push i_wr_data
//   i_wr_data   : word to push
//   i_rd_en     : pop the head word
//   o_rd_data   : current head word (valid while !o_empty)
//   o_full      : FIFO holds DEPTH words
//   o_empty     : FIFO holds no words
// -----------------------------------------------------------------------------
module hdd_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic [AW:0]   w_count_nxt;

    assign w_count_nxt = r_count + (AW+1)'(i_wr_en) - (AW+1)'(i_rd_en);

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/hdd_byte_serializer.sv
// -----------------------------------------------------------------------------
// hdd_byte_serializer
// Buffers hard-decision words from the decoder (no backpressure) and emits
// them MSB byte first over a valid/ready handshake. Tracks codeword framing
// and flags dropped words.
// Build option: define HDD_FRAME_MARKER_EN to emit SYNC_BYTE ahead of the
// first word of every frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : decoder word strobe
//   in_data     : decoder word (HDDW bits)
//   out_data    : byte to UART FIFO
//   out_valid   : out_data valid
//   out_ready   : UART FIFO accepts
//   overflow    : sticky, a word was dropped because the FIFO was full
//   frame_done  : pulses on the handshake of the last byte of a frame
// -----------------------------------------------------------------------------
module hdd_byte_serializer
    import hdd_ser_pkg::*;
#(
    parameter int         HDDW        = 32,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         FIFO_AW     = 3,
    parameter int         FRAME_WORDS = 255,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [HDDW-1:0] in_data,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overflow,
    output logic            frame_done
);

    localparam int BPW  = bytes_per_word(HDDW);
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WCW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
`ifdef HDD_FRAME_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    ser_state_e      r_state;
    logic [HDDW-1:0] r_shift;
    logic [IDXW-1:0] r_byte_idx;
    logic [WCW-1:0]  r_word_cnt;
    logic            r_overflow;

    logic [HDDW-1:0] w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic            w_hs;
    logic            w_last_byte;
    logic            w_last_word;
    logic            w_more;
    logic [WCW-1:0]  w_word_cnt_nxt;

    // A pop only ever happens in LOAD, so a write while full is only safe then.
    assign w_pop  = (r_state == ST_LOAD);
    assign w_wr   = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    hdd_word_fifo #(
        .W     (HDDW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign out_valid = (r_state == ST_SYNC) || (r_state == ST_SHIFT);
    assign out_data  = (r_state == ST_SHIFT) ? r_shift[HDDW-1 -: 8] :
                       (r_state == ST_SYNC)  ? SYNC_BYTE : 8'h00;
    assign w_hs      = out_valid && out_ready;

    assign w_last_byte    = (r_byte_idx == IDXW'(BPW - 1));
    assign w_last_word    = (r_word_cnt == WCW'(FRAME_WORDS - 1));
    assign w_word_cnt_nxt = w_last_word ? '0 : r_word_cnt + 1'b1;
    // Looking at the incoming write as well as the registered empty flag lets
    // an idle serializer reach LOAD in the cycle right after the write.
    assign w_more         = !w_empty || w_wr;

    assign frame_done = (r_state == ST_SHIFT) && w_hs && w_last_byte && w_last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_more)
                        r_state <= (MARKER_EN && r_word_cnt == '0) ? ST_SYNC : ST_LOAD;
                end
                ST_SYNC: begin
                    if (w_hs) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift    <= w_head;
                    r_byte_idx <= '0;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_hs) begin
                        if (w_last_byte) begin
                            r_word_cnt <= w_word_cnt_nxt;
                            r_byte_idx <= '0;
                            // A frame boundary reached with data waiting still
                            // needs its marker, so it cannot go straight to LOAD.
                            if (w_more)
                                r_state <= (MARKER_EN && w_word_cnt_nxt == '0) ? ST_SYNC : ST_LOAD;
                            else
                                r_state <= ST_IDLE;
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_hdd_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_hdd_byte_serializer
// Scoreboard bench: every accepted word pushes its expected bytes (and the
// expected frame_done flag per byte) into a queue; a negedge monitor pops and
// compares on each handshake and checks output hold during stalls.
// -----------------------------------------------------------------------------
module tb_hdd_byte_serializer;

    localparam int HDDW = 32;
    localparam int FW   = 255;
`ifdef HDD_FRAME_MARKER_EN
    localparam bit MARKER = 1'b1;
`else
    localparam bit MARKER = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         fd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [HDDW-1:0] in_data;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            overflow;
    logic            frame_done;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   widx   = 0;
    int   hs_cnt = 0;
    int   fd_exp = 0;
    int   fd_seen = 0;

    hdd_byte_serializer #(
        .HDDW        (HDDW),
        .FIFO_DEPTH  (8),
        .FIFO_AW     (3),
        .FRAME_WORDS (FW),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference: a word is a stream of bytes, most significant first; word
    // number k of a frame (k = widx mod FW) closes the frame when k == FW-1.
    function automatic void model_push(input logic [31:0] w);
        exp_t e;
        if (MARKER && (widx % FW) == 0) begin
            e.d = 8'hA5; e.fd = 1'b0; q.push_back(e);
        end
        for (int b = 0; b < 4; b++) begin
            e.d  = 8'((w >> (24 - 8 * b)) & 32'hFF);
            e.fd = (b == 3) && ((widx % FW) == FW - 1);
            if (e.fd) fd_exp++;
            q.push_back(e);
        end
        widx++;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_word(input logic [31:0] w, input bit acc);
        in_valid = 1'b1;
        in_data  = w;
        if (acc) model_push(w);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk({name, "_drain_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_hs(input int target, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk); #1;
            if (hs_cnt >= target) done = 1'b1;
        end
        chk({name, "_hs_reached"}, 32'(done), 32'd1);
    endtask

    // Monitor: compares each accepted byte, checks hold during stalls and
    // flags any frame_done outside a handshake.
    initial begin
        exp_t e;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_data !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b d=%0h expected v=1 d=%0h",
                                 out_valid, out_data, prev_data);
                    end
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (frame_done) fd_seen++;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %0h expected none", out_data);
                    end else begin
                        e = q.pop_front();
                        if (out_data !== e.d) begin
                            errors++;
                            $display("FAIL byte: got %0h expected %0h", out_data, e.d);
                        end
                        checks++;
                        if (frame_done !== e.fd) begin
                            errors++;
                            $display("FAIL frame_done: got %0b expected %0b", frame_done, e.fd);
                        end
                    end
                end else if (frame_done) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_frame_done: got 1 expected 0");
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        int base;
        int sent;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Latency from idle: LOAD in the next cycle, first byte one after.
        drive_word(32'h11223344, 1'b1);
        in_valid = 1'b0;
`ifndef HDD_FRAME_MARKER_EN
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("lat_t2_data", 32'(out_data), 32'h11);
`endif
        drain("single");

        // Stall mid-word: ready 1,0,0,1 holds byte 22.
        drive_word(32'h11223344, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_c1_data", 32'(out_data), 32'h22);
        @(posedge clk); #1;
        chk("stall_c2_data", 32'(out_data), 32'h22);
        chk("stall_c2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain("stall");

        // Fill: one word in the shift register, eight in the FIFO.
        out_ready = 1'b0;
        drive_word(32'hA0A1A2A3, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) drive_word(32'hB0000000 + 32'(i), 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_no_overflow", 32'(overflow), 32'd0);
        // Release so the held word finishes; the next cycle is the pop.
        base = hs_cnt;
        out_ready = 1'b1;
        wait_hs(base + 4, "fill");
        out_ready = 1'b0;
        drive_word(32'hC0C1C2C3, 1'b1);   // written while full, in the pop cycle
        chk("push_pop_full_no_ovf", 32'(overflow), 32'd0);
        drive_word(32'hDEAD0001, 1'b0);   // dropped
        chk("overflow_set", 32'(overflow), 32'd1);
        drive_word(32'hDEAD0002, 1'b0);   // dropped
        in_valid = 1'b0;
        base = hs_cnt;
        out_ready = 1'b1;
        drain("overflow");
        chk("overflow_bytes", 32'(hs_cnt - base), 32'd36);
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-word after two bytes.
        out_ready = 1'b0;
        drive_word(32'hCAFEF00D, 1'b1);
        in_valid = 1'b0;
        base = hs_cnt;
        out_ready = 1'b1;
        wait_hs(base + 2, "midword");
        out_ready = 1'b0;
        rst = 1'b1;
        q.delete();
        widx = 0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive_word(32'h0A0B0C0D, 1'b1);
        in_valid = 1'b0;
        drain("after_rst");

        // Random stream across a frame boundary.
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 300; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (q.size() <= 16 && $urandom_range(0, 1) == 1) begin
                drive_word($urandom, 1'b1);
                sent++;
            end else begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("random_words_sent", 32'(sent), 32'd300);
        drain("random");
        chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
        chk("frame_done_total", 32'(fd_exp), 32'd1);
        chk("no_overflow_random", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
